schwap_bank_ctrl: RTL

- Sequencer and owner of the bank-select interface of the banked (schwap) register file: 16 banks x 4 regs x 16 bits, bank latched on rising edge of schwapClk from schwapReg.
- Accepts call-style push / return-style pop / replace requests from control, keeps a LIFO of previously active banks, and generates the setup/strobe/settle sequence on schwapReg/schwapClk.
- Gates register-file writes while a bank switch is in flight.
- Sits between the control unit and the schwap register file.

---
 rtl/schwap_bank_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/schwap_bank_ctrl.sv
// Bank-select sequencer for the schwap register file.
// It keeps a LIFO of saved banks and drives the setup/strobe/settle handshake on schwapReg/schwapClk.
module schwap_bank_ctrl #(
   parameter int BANK_W      = 4,
   parameter int STACK_DEPTH = 8,
   parameter int RESET_BANK  = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [BANK_W-1:0]             targetBank,
   input  logic                          writeIn,
   output logic                          writeOut,
   output logic [BANK_W-1:0]             schwapReg,
   output logic                          schwapClk,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow,
   output logic                          underflow,
   output logic [BANK_W-1:0]             curBank,
   output logic [$clog2(STACK_DEPTH):0]  depth
);

   localparam int PTR_W   = $clog2(STACK_DEPTH);
   localparam int DEPTH_W = PTR_W + 1;
   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] DEPTH_ZERO = DEPTH_W'(0);
   localparam logic [BANK_W-1:0]  RST_BANK   = BANK_W'(RESET_BANK);

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_SETTLE = 3'd4
   } state_t;

   state_t            state_r;
   logic              init_run_r;
   logic [BANK_W-1:0] stack_r [STACK_DEPTH];
   logic              stack_we_s;
   logic [PTR_W-1:0]  push_idx_s;
   logic [PTR_W-1:0]  pop_idx_s;

   // Writes are blocked combinationally so nothing lands in a half-switched bank.
   assign writeOut = writeIn & ~busy;

   // Stack pointer decode and push-accept strobe.
   always_comb begin
      stack_we_s = 1'b0;
      push_idx_s = PTR_W'(depth);
      pop_idx_s  = PTR_W'(depth - DEPTH_ONE);
      if ((state_r == ST_IDLE) && push && !pop && (depth != DEPTH_FULL)) begin
         stack_we_s = 1'b1;
      end else begin
         stack_we_s = 1'b0;
      end
   end

   // Saved-bank storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (stack_we_s) begin
         stack_r[push_idx_s] <= curBank;
      end
   end

   // Sequencer: request decode in IDLE, then SETUP -> STROBE -> SETTLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_INIT;
         init_run_r <= 1'b1;
         schwapReg  <= RST_BANK;
         curBank    <= RST_BANK;
         schwapClk  <= 1'b0;
         busy       <= 1'b1;
         done       <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         depth      <= DEPTH_ZERO;
      end else begin
         done      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         case (state_r)
            ST_INIT: begin
               state_r    <= ST_STROBE;
               init_run_r <= 1'b1;
               schwapClk  <= 1'b1;
               busy       <= 1'b1;
            end
            ST_IDLE: begin
               schwapClk <= 1'b0;
               busy      <= 1'b0;
               if (push && pop) begin
                  schwapReg  <= targetBank;
                  state_r    <= ST_SETUP;
                  busy       <= 1'b1;
                  init_run_r <= 1'b0;
               end else if (push) begin
                  if (depth == DEPTH_FULL) begin
                     overflow <= 1'b1;
                  end else begin
                     depth      <= depth + DEPTH_ONE;
                     schwapReg  <= targetBank;
                     state_r    <= ST_SETUP;
                     busy       <= 1'b1;
                     init_run_r <= 1'b0;
                  end
               end else if (pop) begin
                  if (depth == DEPTH_ZERO) begin
                     underflow <= 1'b1;
                  end else begin
                     depth      <= depth - DEPTH_ONE;
                     schwapReg  <= stack_r[pop_idx_s];
                     state_r    <= ST_SETUP;
                     busy       <= 1'b1;
                     init_run_r <= 1'b0;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               state_r   <= ST_STROBE;
               schwapClk <= 1'b1;
            end
            ST_STROBE: begin
               state_r   <= ST_SETTLE;
               schwapClk <= 1'b0;
            end
            ST_SETTLE: begin
               // The power-up strobe is not a requested switch, so it raises no done.
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               done    <= ~init_run_r;
               curBank <= schwapReg;
            end
            default: begin
               state_r   <= ST_INIT;
               schwapClk <= 1'b0;
               busy      <= 1'b1;
            end
         endcase
      end
   end

endmodule
